game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Top-level sequencer for the coin catcher game. It moves the game through idle, pre-game countdown, play and game-over phases. It gates game_core and game_timer through enable, load and clear strobes, and it keeps a session high score. It sits between the debounced button and freq_div strobes on one side and game_core / game_timer / seg_decoder on the other.

Parameters:
READY_TICKS, 3, number of 1 Hz ticks spent in the pre-game countdown (1..15)
OVER_HOLD, 5, number of 1 Hz ticks spent in game-over before auto-return to IDLE (1..15)

Ports:
clk  input  1  system clock; all logic is on this single clock
reset  input  1  synchronous, active-low reset
tick_1hz  input  1  single-cycle 1 Hz strobe, synchronous to clk
btn_start  input  1  debounced start button, level
time_up  input  1  level from game_timer; high when the countdown reaches 0
score  input  8  current score from game_core, unsigned
state  output  2  IDLE=0, READY=1, PLAY=2, OVER=3
ready_count  output  4  remaining pre-game seconds; 0 outside READY
game_en  output  1  enables game_core movement/scoring; high only in PLAY
timer_en  output  1  enables game_timer decrement; high only in PLAY
timer_load  output  1  1-cycle pulse that reloads game_timer to its start value
core_clear  output  1  1-cycle pulse that clears game_core score and positions
high_score  output  8  best score since reset
new_record  output  1  high in OVER when the last game set a new high score

Behaviour:
- Reset: sampled on the clk edge only, while reset==0. Values after reset: state=IDLE, ready_count=0, game_en=0, timer_en=0, timer_load=0, core_clear=0, high_score=0, new_record=0, internal hold counter=0, start-edge register=0.
- Start edge: start_q is btn_start registered once. start_rise = btn_start & ~start_q. Only start_rise is acted on; a held button never causes a second start.
- All outputs are registered. An output changes on the clk edge that samples its triggering input (1-cycle latency).
- IDLE: on start_rise, go to READY. In the same edge: ready_count=READY_TICKS, timer_load=1, core_clear=1. Both pulses last exactly one cycle.
- READY: on each tick_1hz, ready_count decrements.
  - When tick_1hz arrives with ready_count==1: go to PLAY, ready_count=0, game_en=1, timer_en=1.
  - start_rise and time_up are ignored in READY.
- PLAY: game_en=timer_en=1.
  - When time_up==1: go to OVER and drop game_en/timer_en on that edge.
  - Same edge: if score > high_score (unsigned), high_score<=score and new_record<=1. Equal score does not set a record.
  - Hold counter loads OVER_HOLD.
  - start_rise is ignored in PLAY.
- OVER: on each tick_1hz, the hold counter decrements.
  - start_rise (priority) acts as the IDLE start: go to READY with timer_load and core_clear pulses, and new_record clears.
  - Otherwise, when tick_1hz arrives with hold==1: go to IDLE and clear new_record.
  - If start_rise and tick_1hz land on the same cycle, the start wins.
- tick_1hz on the same cycle as a state entry is not counted toward the new state's counter.
- Reset mid-game: full return to reset values, including high_score.
- Counters never underflow: the transition fires at 1, and the counter is loaded on entry.
- Illegal state encodings: none, since 2 bits cover 4 states. The default branch returns to IDLE.

Decomposition:
- Shared package/include: state encodings ST_IDLE, ST_READY, ST_PLAY, ST_OVER (2-bit), and the 4-bit tick counter width.
- Sub-module tick_counter: a loadable 4-bit down-counter with tick enable and an is_one flag. It is instantiated twice (ready countdown and over hold).
- Everything else lives in one FSM module.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> state=0, all strobes 0, high_score=0, ready_count=0.
- btn_start held high 100 cycles in IDLE -> exactly one timer_load and one core_clear pulse, state=1, ready_count=3. After 3 tick_1hz pulses -> state=2, game_en=1, timer_en=1, ready_count=0.
- In PLAY with score=42 and high_score=0, assert time_up -> next edge state=3, game_en=0, high_score=42, new_record=1. A second game ending with score=42 -> high_score stays 42, new_record=0.
- In OVER, give no start and 5 tick_1hz pulses -> state=0 and new_record=0 after the 5th tick, not before.
- In OVER, raise start_rise on the same cycle as the final hold tick -> state=1 (READY), timer_load and core_clear pulse once, high_score retained.
- Drive reset=0 for one cycle during PLAY with high_score=42 -> state=0, game_en=0, high_score=0. btn_start pulses during READY/PLAY cause no state change.

Source files
------------

// File: rtl/game_flow_ctrl_pkg.sv
// Shared state encodings and counter width
// for the coin catcher game flow sequencer.
package game_flow_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/game_flow_ctrl_tick.sv
// Loadable down-counter stepped by a tick
// enable, flagging when it sits at one.
module tick_counter
  import game_flow_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count  = cnt_q;
  assign is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Game phase sequencer: idle, countdown,
// play and game-over, plus session high score.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int READY_TICKS = 3,
  parameter int OVER_HOLD   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_start,
  input  logic       time_up,
  input  logic [7:0] score,
  output logic [1:0] state,
  output logic [3:0] ready_count,
  output logic       game_en,
  output logic       timer_en,
  output logic       timer_load,
  output logic       core_clear,
  output logic [7:0] high_score,
  output logic       new_record
);

  state_t     state_q, state_d;
  logic       start_q;
  logic       en_q, en_d;
  logic       pulse_q, pulse_d;
  logic [7:0] high_q, high_d;
  logic       rec_q, rec_d;

  logic       rdy_load, rdy_tick, rdy_one;
  logic       hold_load, hold_tick, hold_one;
  logic [CNT_W-1:0] rdy_cnt, hold_cnt;

  logic start_rise;
  assign start_rise = btn_start & ~start_q;

  assign rdy_tick  = tick_1hz
                   & (state_q == ST_READY);
  // start in OVER reloads READY; hold stays put
  assign hold_tick = tick_1hz
                   & (state_q == ST_OVER)
                   & ~start_rise
                   & (hold_cnt != '0);

  tick_counter u_ready_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rdy_load),
    .load_val (CNT_W'(READY_TICKS)),
    .tick     (rdy_tick),
    .count    (rdy_cnt),
    .is_one   (rdy_one)
  );

  tick_counter u_hold_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_val (CNT_W'(OVER_HOLD)),
    .tick     (hold_tick),
    .count    (hold_cnt),
    .is_one   (hold_one)
  );

  always_comb begin
    state_d   = state_q;
    en_d      = 1'b0;
    pulse_d   = 1'b0;
    high_d    = high_q;
    rec_d     = rec_q;
    rdy_load  = 1'b0;
    hold_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d  = ST_READY;
          rdy_load = 1'b1;
          pulse_d  = 1'b1;
        end
      end
      ST_READY: begin
        if (tick_1hz && rdy_one) begin
          state_d = ST_PLAY;
          en_d    = 1'b1;
        end
      end
      ST_PLAY: begin
        en_d = 1'b1;
        if (time_up) begin
          state_d   = ST_OVER;
          en_d      = 1'b0;
          hold_load = 1'b1;
          rec_d     = (score > high_q);
          if (score > high_q) high_d = score;
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          state_d  = ST_READY;
          rdy_load = 1'b1;
          pulse_d  = 1'b1;
          rec_d    = 1'b0;
        end else if (tick_1hz && hold_one) begin
          state_d = ST_IDLE;
          rec_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      pulse_q <= 1'b0;
      high_q  <= '0;
      rec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= btn_start;
      en_q    <= en_d;
      pulse_q <= pulse_d;
      high_q  <= high_d;
      rec_q   <= rec_d;
    end
  end

  assign state       = state_q;
  assign ready_count = rdy_cnt;
  assign game_en     = en_q;
  assign timer_en    = en_q;
  assign timer_load  = pulse_q;
  assign core_clear  = pulse_q;
  assign high_score  = high_q;
  assign new_record  = rec_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scoreboard bench for game_flow_ctrl.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       btn_start;
  logic       time_up;
  logic [7:0] score;
  logic [1:0] state;
  logic [3:0] ready_count;
  logic       game_en;
  logic       timer_en;
  logic       timer_load;
  logic       core_clear;
  logic [7:0] high_score;
  logic       new_record;

  int n_cmp = 0;
  int n_bad = 0;
  int aux   = 0;

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .READY_TICKS (3),
    .OVER_HOLD   (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .btn_start   (btn_start),
    .time_up     (time_up),
    .score       (score),
    .state       (state),
    .ready_count (ready_count),
    .game_en     (game_en),
    .timer_en    (timer_en),
    .timer_load  (timer_load),
    .core_clear  (core_clear),
    .high_score  (high_score),
    .new_record  (new_record)
  );

  function automatic int obs(int sel);
    case (sel)
      0: return int'(state);
      1: return int'(ready_count);
      2: return int'(game_en);
      3: return int'(timer_en);
      4: return int'(timer_load);
      5: return int'(core_clear);
      6: return int'(high_score);
      7: return int'(new_record);
      default: return aux;
    endcase
  endfunction

  task automatic push(string tag, int sel, int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    int o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      n_cmp++;
      assert (o === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%0d expected=%0d",
               e.tag, o, e.val);
      end
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
  endtask

  initial begin
    int tl_n;
    int cc_n;
    reset     = 1'b0;
    tick_1hz  = 1'b0;
    btn_start = 1'b0;
    time_up   = 1'b0;
    score     = 8'd0;
    step(2);
    reset = 1'b1;
    push("rst_state", 0, 0);
    push("rst_rc", 1, 0);
    push("rst_ge", 2, 0);
    push("rst_te", 3, 0);
    push("rst_tl", 4, 0);
    push("rst_cc", 5, 0);
    push("rst_hs", 6, 0);
    push("rst_nr", 7, 0);
    chk();

    // held start: one pulse only
    tl_n = 0;
    cc_n = 0;
    btn_start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      tl_n += int'(timer_load);
      cc_n += int'(core_clear);
    end
    btn_start = 1'b0;
    aux = tl_n;
    push("hold_tl_cnt", 8, 1);
    chk();
    aux = cc_n;
    push("hold_cc_cnt", 8, 1);
    chk();
    push("hold_state", 0, 1);
    push("hold_rc", 1, 3);
    chk();

    tick();
    tick();
    push("rdy2_state", 0, 1);
    push("rdy2_rc", 1, 1);
    chk();
    tick();
    push("play_state", 0, 2);
    push("play_ge", 2, 1);
    push("play_te", 3, 1);
    push("play_rc", 1, 0);
    chk();

    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    step(1);
    push("play_btn_state", 0, 2);
    push("play_btn_tl", 4, 0);
    chk();

    score   = 8'd42;
    time_up = 1'b1;
    step(1);
    time_up = 1'b0;
    push("over_state", 0, 3);
    push("over_ge", 2, 0);
    push("over_te", 3, 0);
    push("over_hs", 6, 42);
    push("over_nr", 7, 1);
    chk();

    repeat (4) tick();
    push("over4_state", 0, 3);
    push("over4_nr", 7, 1);
    chk();
    tick();
    push("over5_state", 0, 0);
    push("over5_nr", 7, 0);
    chk();

    // second game, equal score
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    push("g2_state", 0, 1);
    push("g2_tl", 4, 1);
    push("g2_cc", 5, 1);
    chk();
    repeat (3) tick();
    push("g2_play", 0, 2);
    chk();
    time_up = 1'b1;
    step(1);
    time_up = 1'b0;
    push("g2_over", 0, 3);
    push("g2_hs", 6, 42);
    push("g2_nr", 7, 0);
    chk();

    // start on final hold tick
    repeat (4) tick();
    btn_start = 1'b1;
    tick_1hz  = 1'b1;
    step(1);
    tick_1hz  = 1'b0;
    push("race_state", 0, 1);
    push("race_tl", 4, 1);
    push("race_cc", 5, 1);
    push("race_hs", 6, 42);
    push("race_rc", 1, 3);
    chk();
    step(1);
    push("race_tl_end", 4, 0);
    push("race_cc_end", 5, 0);
    chk();

    btn_start = 1'b0;
    step(1);
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    push("rdy_btn_state", 0, 1);
    push("rdy_btn_rc", 1, 3);
    push("rdy_btn_tl", 4, 0);
    chk();

    // new record above previous best
    repeat (3) tick();
    score   = 8'd99;
    time_up = 1'b1;
    step(1);
    time_up = 1'b0;
    push("g3_hs", 6, 99);
    push("g3_nr", 7, 1);
    chk();

    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    push("g4_nr", 7, 0);
    chk();
    repeat (3) tick();
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    push("mid_rst_state", 0, 0);
    push("mid_rst_ge", 2, 0);
    push("mid_rst_hs", 6, 0);
    push("mid_rst_rc", 1, 0);
    chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
